// File: rtl/fp_arb_pkg.sv
// Shared definitions for the FP unit arbiter.
// Holds the FSM encoding and default unit latencies.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FP_ADD_LAT = 10;
  localparam int FP_MUL_LAT = 10;
  localparam int FP_CMP_LAT = 10;

endpackage

// File: rtl/fp_rr_pick.sv
// Round-robin selector: first set req bit at or above ptr, wrapping.
// Purely combinational; returns one-hot owner and its index.
module fp_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] owner_oh,
  output logic [IDX_W-1:0]   owner_idx
);

  function automatic int slot(
    input logic [IDX_W-1:0] p,
    input int               k
  );
    return (int'(p) + k) % NUM_REQ;
  endfunction

  // Scan farthest-first so the nearest hit overwrites the rest.
  always_comb begin
    owner_oh  = '0;
    owner_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[slot(ptr, k)]) begin
        owner_oh               = '0;
        owner_oh[slot(ptr, k)] = 1'b1;
        owner_idx              = IDX_W'(slot(ptr, k));
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one multi-cycle FP unit between NUM_REQ stage controllers.
// FP_ARB_FIXED_PRIORITY_EN: lowest-index requester wins, no pointer.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int OP_LATENCY = FP_ADD_LAT,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b_i,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         result_o,
  output logic                          fu_en,
  output logic [DATA_WIDTH-1:0]         fu_a,
  output logic [DATA_WIDTH-1:0]         fu_b,
  input  logic [DATA_WIDTH-1:0]         fu_result,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state;
  state_e               state_nx;
  logic [NUM_REQ-1:0]   own_oh;
  logic [IDX_W-1:0]     own_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last;

  assign last = (cnt == CNT_WIDTH'(OP_LATENCY - 1));

`ifdef FP_ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;

  fp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .owner_oh  (pick_oh),
    .owner_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == DONE) begin
      ptr <= (own_idx == IDX_W'(NUM_REQ - 1))
           ? '0 : own_idx + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt      = '0;
    done     = '0;
    fu_en    = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) state_nx = ISSUE;
      end
      ISSUE: begin
        gnt      = own_oh;
        busy     = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        gnt   = own_oh;
        busy  = 1'b1;
        fu_en = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        gnt      = own_oh;
        done     = own_oh;
        busy     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Operands are taken from the registered owner, never straight from req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_oh   <= '0;
      own_idx  <= '0;
      cnt      <= '0;
      fu_a     <= '0;
      fu_b     <= '0;
      result_o <= '0;
    end else begin
      if (state == IDLE && |req) begin
        own_oh  <= pick_oh;
        own_idx <= pick_idx;
      end
      if (state == ISSUE) begin
        cnt  <= '0;
        fu_a <= op_a_i[int'(own_idx)*DATA_WIDTH +: DATA_WIDTH];
        fu_b <= op_b_i[int'(own_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == EXEC) begin
        cnt <= cnt + CNT_WIDTH'(1);
        if (last) result_o <= fu_result;
      end
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: timeline reference model, random requesters.
// A toy FP adder stands in for the shared unit.
module tb_fp_unit_arbiter;

  localparam int N = 3;
  localparam int W = 32;
  localparam int L = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] op_a = '0;
  logic [N*W-1:0] op_b = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result, fu_a, fu_b, fu_result;
  logic           fu_en, busy;
  int             en_cnt;

  always #5 clk = ~clk;

  fp_unit_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .OP_LATENCY (L),
    .CNT_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .gnt       (gnt),
    .done      (done),
    .result_o  (result),
    .fu_en     (fu_en),
    .fu_a      (fu_a),
    .fu_b      (fu_b),
    .fu_result (fu_result),
    .busy      (busy)
  );

  // Positive normal single-precision add, truncating.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  e;
    logic [24:0] mx, my, s;
    int          d;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = (d > 24) ? '0 : ({2'b01, y[22:0]} >> d);
    s  = mx + my;
    e  = x[30:23];
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  // Unit output is only meaningful in the final enabled cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) en_cnt <= 0;
    else        en_cnt <= fu_en ? en_cnt + 1 : 0;

  assign fu_result = (fu_en && en_cnt == L - 1)
                   ? fadd(fu_a, fu_b) : (32'hBAD0_0000 | 32'(en_cnt));

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          act = 0;
  int          t0, own, ptr = 0, ts;
  logic [31:0] ea, eb, last_res = '0;
  logic [N-1:0] prev_done = '0;
  int          done_own[$];
  int          done_cyc[$];
  int          exp_ord[4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef FP_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Called at posedge+1 with this cycle's inputs applied.
  task automatic step();
    logic [N-1:0] eg, ed;
    logic         ee, eb_busy;
    int           off;
    @(negedge clk);
    eg = '0; ed = '0; ee = 1'b0; eb_busy = 1'b0; off = -1;
    if (act) begin
      off     = cyc - t0;
      eg      = N'(1) << own;
      eb_busy = 1'b1;
      ee      = (off >= 2 && off <= L + 1);
      if (off == 1) begin
        ea = op_a[own*W +: W];
        eb = op_b[own*W +: W];
      end
      if (ee) begin
        chk("fu_a", fu_a, ea);
        chk("fu_b", fu_b, eb);
      end
      if (off == L + 2) begin
        ed       = eg;
        last_res = fadd(ea, eb);
      end
    end
    chk("ctl", {gnt, done, fu_en, busy}, {eg, ed, ee, eb_busy});
    chk("result", result, last_res);
    prev_done = done;
    if (act && off == L + 2) begin
      done_own.push_back(own);
      done_cyc.push_back(cyc);
      act = 0;
      ptr = (own + 1) % N;
    end else if (!act && req != '0) begin
      own = pick(req);
      t0  = cyc;
      act = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {gnt, done, fu_en, busy}, '0);
    chk("rst_res", result, '0);
    chk("rst_fu", {fu_a, fu_b}, '0);
    act = 0; ptr = 0; last_res = '0; prev_done = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    done_own.delete();
    done_cyc.delete();
  endtask

  initial begin
    #1;
    do_reset();

    // idle after reset
    repeat (20) step();

    // single request from requester 1: 1.0 + 2.0
    clear_log();
    op_a[W +: W] = 32'h3F80_0000;
    op_b[W +: W] = 32'h4000_0000;
    req = 3'b010;
    ts  = cyc;
    repeat (L + 3) step();
    req = '0;
    chk("t2_ndone", done_own.size(), 1);
    chk("t2_owner", done_own[0], 1);
    chk("t2_lat", done_cyc[0] - ts, L + 2);
    chk("t2_res", result, 32'h4040_0000);
    repeat (3) step();

    // all requesting from reset
    do_reset();
    clear_log();
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = rnd_op();
      op_b[i*W +: W] = rnd_op();
    end
`ifdef FP_ARB_FIXED_PRIORITY_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 0};
`endif
    req = 3'b111;
    repeat (4 * (L + 3)) step();
    req = '0;
    chk("t3_ndone", done_own.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", done_own[i], exp_ord[i]);
    for (int i = 0; i < 3; i++) chk("t3_gap", done_cyc[i+1] - done_cyc[i], L + 3);
    repeat (3) step();

    // owner drops req in the third EXEC cycle
    clear_log();
    op_a[0 +: W] = rnd_op();
    op_b[0 +: W] = rnd_op();
    req = 3'b001;
    ts  = cyc;
    for (int c = 0; c < L + 3; c++) begin
      if (c == 4) req = '0;
      step();
    end
    chk("t4_ndone", done_own.size(), 1);
    chk("t4_owner", done_own[0], 0);
    chk("t4_lat", done_cyc[0] - ts, L + 2);
    repeat (2) step();

    // reset in the middle of EXEC
    op_a[W +: W] = rnd_op();
    op_b[W +: W] = rnd_op();
    req = 3'b010;
    repeat (6) step();
    do_reset();
    clear_log();
    op_a[2*W +: W] = rnd_op();
    op_b[2*W +: W] = rnd_op();
    req = 3'b100;
    repeat (L + 3) step();
    req = '0;
    chk("t5_ndone", done_own.size(), 1);
    chk("t5_owner", done_own[0], 2);
    repeat (2) step();

    // random requesters
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (prev_done[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i]         = 1'b1;
          op_a[i*W +: W] = rnd_op();
          op_b[i*W +: W] = rnd_op();
        end
      end
      step();
    end
    req = '0;
    repeat (L + 5) step();
    chk("drain_idle", act, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one multi-cycle floating-point execution unit (adder or multiplier) between NUM_REQ MFCC stage controllers, for example amplitude, mel-filter and log.
- Each requester raises req with its operands. The arbiter grants one requester, latches its operands and drives the unit for OP_LATENCY cycles.
- When the operation completes, it returns the result and pulses done to that requester.
- Sits between the per-stage state controllers and the shared FP datapath. It replaces per-stage counter-based waiting on the unit.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 32, operand and result width (IEEE-754 single).
- OP_LATENCY, 10, cycles the FP unit needs from enable to a valid result (1..15).
- CNT_WIDTH, 4, latency counter width; must satisfy 2^CNT_WIDTH > OP_LATENCY.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester operation request, level
- op_a_i  input  NUM_REQ*DATA_WIDTH  packed operand A; requester i occupies slice i
- op_b_i  input  NUM_REQ*DATA_WIDTH  packed operand B
- gnt  output  NUM_REQ  one-hot grant, held ISSUE through DONE
- done  output  NUM_REQ  one-cycle completion pulse to the owner
- result_o  output  DATA_WIDTH  registered result; valid while done is high, held until next capture
- fu_en  output  1  FP unit enable, high throughout EXEC
- fu_a  output  DATA_WIDTH  latched operand A to the unit
- fu_b  output  DATA_WIDTH  latched operand B to the unit
- fu_result  input  DATA_WIDTH  FP unit output
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - state = IDLE, priority pointer = 0, counter = 0.
  - gnt, done, fu_en, busy = 0; result_o, fu_a, fu_b = 0.
- Reset asserted mid-operation aborts immediately. No done pulse is emitted and the result is discarded.
- FSM states: IDLE, ISSUE, EXEC, DONE.
- IDLE:
  - If req != 0, select the owner by round-robin: first set bit at or above the pointer, wrapping.
  - Register the owner and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - gnt[owner] = 1.
  - Latch the owner's op_a_i/op_b_i slices into fu_a/fu_b.
  - Clear the counter and go to EXEC.
- EXEC:
  - fu_en = 1; counter increments each cycle.
  - When counter == OP_LATENCY-1: capture fu_result into result_o and go to DONE.
- DONE (1 cycle):
  - done[owner] = 1; gnt is still held.
  - Pointer = owner+1, wrapping from NUM_REQ-1 to 0.
  - Go to IDLE.
- Latency: req first seen high in IDLE at cycle 0 gives:
  - gnt from cycle 1;
  - fu_en in cycles 2..OP_LATENCY+1;
  - done and a valid result_o at cycle OP_LATENCY+2.
- Back-to-back: at least one IDLE bubble separates operations. Sustained throughput is one operation per OP_LATENCY+3 cycles.
- Handshake:
  - A requester holds req and its operands stable until ISSUE. Operands are don't-care after ISSUE.
  - A requester drops req in the cycle after done. A req still high in the IDLE cycle after DONE is treated as a new request.
  - req deasserting during ISSUE or EXEC does not abort; done still pulses to the original owner.
- Simultaneous requests: with all req bits high, grant order from reset is 0,1,2,0,...
- Non-owner req changes during an operation are ignored until IDLE.
- fu_a/fu_b hold their last value outside EXEC. No combinational path exists from req to fu_*.
- OP_LATENCY=1: EXEC lasts exactly one cycle.

Optional Feature:
- Macro: FP_ARB_FIXED_PRIORITY_EN.
- Defined: owner = lowest-index set req bit; the pointer register is removed.
- Undefined (default): round-robin as specified above.
- All timing is identical in both modes.

Decomposition:
- Package fp_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, EXEC=2'd2, DONE=2'd3);
  - the default OP_LATENCY constants per unit type (FP_ADD_LAT, FP_MUL_LAT, FP_CMP_LAT = 10).
- Sub-module fp_rr_pick: combinational selector (req, pointer) -> one-hot owner plus index. It is instantiated once and replaced by a priority encoder under FP_ARB_FIXED_PRIORITY_EN.

Test Plan:
- Reset then idle, req=0 for 20 cycles -> gnt=0, done=0, fu_en=0, busy=0 throughout.
- req=3'b010 at cycle 0 with A=0x3F800000 and a model unit returning A+B (B=0x40000000) -> gnt=3'b010 at cycle 1, fu_en cycles 2..11, done=3'b010 and result_o=0x40400000 at cycle 12.
- req=3'b111 held continuously -> done order 0,1,2,0. Consecutive done pulses are exactly OP_LATENCY+3=13 cycles apart.
- req[0] dropped in the third EXEC cycle -> operation completes and done[0] still pulses at cycle 12.
- rst_n low during EXEC cycle 5 -> all outputs 0 immediately. After release with req=3'b100, the grant goes to requester 2 with the pointer restarted at 0.
- FP_ARB_FIXED_PRIORITY_EN defined, req=3'b111 held -> requester 0 is granted every operation.
